axi_addr_router: RTL and testbench
==================================

// Module: axi_addr_router
// PURPOSE
//  Sequential successor to the crossbar's combinational request decode, for one AXI address channel.
//  Instantiated once for AR and once for AW.
//  - Decodes each master's address to a slave index.
//  - Runs round-robin arbitration per slave and holds the grant through the address handshake.
//  - Locks the slave to its owner until the final response beat, so the crossbar can route R/B.
// PARAMETERS
//  NUM_M   3   number of masters
//  NUM_S   6   number of mapped slaves; index NUM_S is the default (decode-error) slave
//  ADDR_W  32  address width
// PORTS
//  ACLK        in   1                 clock
//  ARESETn     in   1                 asynchronous reset, active-low
//  AVALID_M    in   NUM_M             master address valid
//  AADDR_M     in   NUM_M x ADDR_W    master address (AXI: stable while AVALID_M is high)
//  AREADY_M    out  NUM_M             address ready returned to each master
//  AVALID_S    out  NUM_S+1           address valid to each slave
//  AREADY_S    in   NUM_S+1           slave address ready
//  SEL_S       out  (NUM_S+1)xNUM_M   one-hot address-mux select per slave (valid in ADDR state)
//  RESP_LAST_S in   NUM_S+1           last response beat handshake done (RLAST&RVALID&RREADY or BVALID&BREADY)
//  OWNER_S     out  (NUM_S+1)xNUM_M   one-hot owner per slave, for response routing (valid in ADDR and RESP)
//  BUSY_S      out  NUM_S+1           slave state != IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; every slave FSM in IDLE; every RR pointer = 0.
//  Decode:
//  - Map is S_BEGIN[s]..S_END[s] inclusive: ROM 0-1FFF, IM 1_0000-1_FFFF, DM 2_0000-2_FFFF,
//    DMA 1002_0000-1002_0200, WDT 1001_0000-1001_03FF, DRAM 2000_0000-201F_FFFF.
//  - A miss routes to slave NUM_S. On multiple hits the lowest s wins.
//  Eligibility: master m requests slave s iff AVALID_M[m], decode(AADDR_M[m])==s, and m owns no slave.
//  - Owning means OWNER_S[x][m]=1 for any x, i.e. one outstanding transaction per master.
//  - This guarantees each master targets at most one slave per cycle; no double grant is possible.
//  Per-slave FSM:
//  - IDLE -> ADDR when any eligible request exists.
//    - Winner = first requester at or after pointer, wrapping modulo NUM_M; registered into SEL_S/OWNER_S.
//  - ADDR:
//    - AVALID_S[s]=1.
//    - AREADY_M[w]=AREADY_S[s]; all other AREADY_M for this slave stay 0.
//    - The address is not re-decoded.
//    - On AREADY_S[s] -> RESP; pointer <= (w+1) mod NUM_M.
//  - RESP: AVALID_S[s]=0, OWNER_S held. On RESP_LAST_S[s] -> IDLE, OWNER_S/SEL_S cleared.
//  Latency and throughput:
//  - AVALID_M to AVALID_S is 1 cycle.
//  - A slave spends at least 1 IDLE cycle between transactions; a new grant is never made in the cycle RESP_LAST_S fires.
//  Edge cases:
//  - A master freed by RESP_LAST_S in cycle t is eligible for arbitration in cycle t+1.
//  - RESP_LAST_S in IDLE or ADDR is ignored.
//  - Requests to a busy slave wait; they are not dropped.
//  - ARESETn asserted mid-transaction clears all state asynchronously; the interrupted transaction is abandoned.
//  - AREADY_M[m] = OR over s of (state ADDR & SEL_S[s][m] & AREADY_S[s]).
// STRUCTURE
//  Package axi_route_pkg:
//  - NUM_S, S_BEGIN/S_END localparam arrays
//  - typedef enum {IDLE, ADDR, RESP} route_state_e
//  - function decode_slave(addr) returning the index, NUM_S on miss
//  Sub-module rr_arbiter #(N):
//  - Inputs req[N], ptr; output one-hot gnt, combinational.
//  - One instance per slave (NUM_S+1 total).
//  - The pointer register and FSM live in axi_addr_router.
// TESTING
//  1 Single: M0 AADDR=0x0002_0004 -> AVALID_S[2]=1 the next cycle, SEL_S[2]=001.
//    AREADY_S[2]=1 -> AREADY_M[0]=1 that cycle.
//    OWNER_S[2]=001 until RESP_LAST_S[2]; BUSY_S[2] then drops the next cycle.
//  2 Round-robin: M0, M1, M2 all hold 0x2000_0000 from reset -> DRAM grants M0, M1, M2 in order.
//    Then M0 re-requests -> M0 granted after M2 completes, not before.
//  3 Map boundaries (one request each, expected slave):
//    0x0000_1FFF->ROM; 0x0000_2000->default(6); 0x1002_0200->DMA; 0x1002_0201->default; 0x201F_FFFF->DRAM.
//  4 Master lock: M0 owns DM in RESP and requests 0x0001_0000 -> IM stays IDLE.
//    RESP_LAST_S[2] -> IM enters ADDR 2 cycles later.
//  5 Parallel: M0->IM and M1->DM in the same cycle -> both slaves enter ADDR together, independent AREADY_M.
//    RESP_LAST_S[1] and a new M2 IM request in the same cycle -> IM idle 1 cycle, then grants M2.
//  6 Reset: ARESETn low while DRAM is in ADDR -> AVALID_S, AREADY_M, OWNER_S, BUSY_S go 0 immediately.
//    After release, pointers are 0 (M0 wins first contention).

Source files
------------

// File: rtl/axi_route_pkg.sv
// Address map, per-slave FSM state type and address decode shared by the address router.
package axi_route_pkg;

    localparam int unsigned NUM_S      = 6;
    localparam int unsigned MAP_ADDR_W = 32;
    localparam int unsigned SIDX_W     = $clog2(NUM_S + 1);

    // ROM, IM, DM, DMA, WDT, DRAM; bounds are inclusive.
    localparam logic [MAP_ADDR_W-1:0] S_BEGIN [NUM_S] = '{
        32'h0000_0000, 32'h0001_0000, 32'h0002_0000,
        32'h1002_0000, 32'h1001_0000, 32'h2000_0000
    };
    localparam logic [MAP_ADDR_W-1:0] S_END [NUM_S] = '{
        32'h0000_1FFF, 32'h0001_FFFF, 32'h0002_FFFF,
        32'h1002_0200, 32'h1001_03FF, 32'h201F_FFFF
    };

    typedef enum logic [1:0] {IDLE, ADDR, RESP} route_state_e;

    function automatic logic [SIDX_W-1:0] decode_slave(input logic [MAP_ADDR_W-1:0] addr);
        logic [SIDX_W-1:0] idx;
        idx = SIDX_W'(NUM_S);
        // Scan downwards so the lowest matching slave has the final say.
        for (int s = int'(NUM_S) - 1; s >= 0; s--) begin
            if (addr >= S_BEGIN[s] && addr <= S_END[s]) begin
                idx = SIDX_W'(s);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
    parameter int unsigned N = 3,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        // First pass covers ptr..N-1, second pass wraps round to 0..ptr-1.
        for (int i = 0; i < int'(N); i++) begin
            if (!found && req[i] && i >= int'(ptr)) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_addr_router.sv
// Registered address-channel router: decode, per-slave round-robin grant, and slave lock
// held until the final response beat so the crossbar can steer R/B back to the owner.
module axi_addr_router
    import axi_route_pkg::*;
#(
    parameter int unsigned NUM_M  = 3,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [NUM_M-1:0]             AVALID_M,
    input  logic [NUM_M-1:0][ADDR_W-1:0] AADDR_M,
    output logic [NUM_M-1:0]             AREADY_M,
    output logic [NUM_S:0]               AVALID_S,
    input  logic [NUM_S:0]               AREADY_S,
    output logic [NUM_S:0][NUM_M-1:0]    SEL_S,
    input  logic [NUM_S:0]               RESP_LAST_S,
    output logic [NUM_S:0][NUM_M-1:0]    OWNER_S,
    output logic [NUM_S:0]               BUSY_S
);

    localparam int unsigned PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    route_state_e                   state_q [NUM_S+1];
    route_state_e                   state_d [NUM_S+1];
    logic [NUM_S:0][NUM_M-1:0]      owner_q, owner_d;
    logic [NUM_S:0][PTR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_S:0][NUM_M-1:0]      req, gnt;
    logic [SIDX_W-1:0]              dec [NUM_M];
    logic [NUM_M-1:0]               busy_m;

    // A master holding any slave may not request another: one outstanding transaction each.
    always_comb begin
        busy_m = '0;
        req    = '0;
        for (int m = 0; m < int'(NUM_M); m++) begin
            dec[m] = decode_slave(MAP_ADDR_W'(AADDR_M[m]));
        end
        for (int s = 0; s <= int'(NUM_S); s++) begin
            busy_m = busy_m | owner_q[s];
        end
        for (int s = 0; s <= int'(NUM_S); s++) begin
            for (int m = 0; m < int'(NUM_M); m++) begin
                req[s][m] = AVALID_M[m] && (dec[m] == SIDX_W'(s)) && !busy_m[m];
            end
        end
    end

    for (genvar s = 0; s <= NUM_S; s++) begin : g_arb
        rr_arbiter #(
            .N (NUM_M)
        ) u_arb (
            .req (req[s]),
            .ptr (ptr_q[s]),
            .gnt (gnt[s])
        );
    end

    always_comb begin
        owner_d = owner_q;
        ptr_d   = ptr_q;
        for (int s = 0; s <= int'(NUM_S); s++) begin
            state_d[s] = state_q[s];
            unique case (state_q[s])
                IDLE: begin
                    if (|gnt[s]) begin
                        state_d[s] = ADDR;
                        owner_d[s] = gnt[s];
                    end
                end
                ADDR: begin
                    if (AREADY_S[s]) begin
                        state_d[s] = RESP;
                        for (int m = 0; m < int'(NUM_M); m++) begin
                            if (owner_q[s][m]) begin
                                ptr_d[s] = (m == int'(NUM_M) - 1) ? '0 : PTR_W'(m + 1);
                            end
                        end
                    end
                end
                RESP: begin
                    if (RESP_LAST_S[s]) begin
                        state_d[s] = IDLE;
                        owner_d[s] = '0;
                    end
                end
                default: state_d[s] = IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int s = 0; s <= int'(NUM_S); s++) begin
                state_q[s] <= IDLE;
            end
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        AREADY_M = '0;
        for (int s = 0; s <= int'(NUM_S); s++) begin
            AVALID_S[s] = (state_q[s] == ADDR);
            BUSY_S[s]   = (state_q[s] != IDLE);
            AREADY_M    = AREADY_M
                        | (owner_q[s] & {NUM_M{(state_q[s] == ADDR) && AREADY_S[s]}});
        end
    end

    assign SEL_S   = owner_q;
    assign OWNER_S = owner_q;

endmodule

// File: tb/tb_axi_addr_router.sv
// Scoreboard bench for axi_addr_router: directed traffic queues expected grants; a monitor
// checks each slave address handshake against them.
module tb_axi_addr_router;

    localparam int NM = 3;
    localparam int NS = 6;

    logic                 ACLK = 1'b0;
    logic                 ARESETn = 1'b0;
    logic [NM-1:0]        AVALID_M;
    logic [NM-1:0][31:0]  AADDR_M;
    logic [NM-1:0]        AREADY_M;
    logic [NS:0]          AVALID_S;
    logic [NS:0]          AREADY_S;
    logic [NS:0][NM-1:0]  SEL_S;
    logic [NS:0]          RESP_LAST_S;
    logic [NS:0][NM-1:0]  OWNER_S;
    logic [NS:0]          BUSY_S;

    typedef struct {
        int         slave;
        logic [2:0] master;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    axi_addr_router #(
        .NUM_M  (NM),
        .ADDR_W (32)
    ) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .AVALID_M    (AVALID_M),
        .AADDR_M     (AADDR_M),
        .AREADY_M    (AREADY_M),
        .AVALID_S    (AVALID_S),
        .AREADY_S    (AREADY_S),
        .SEL_S       (SEL_S),
        .RESP_LAST_S (RESP_LAST_S),
        .OWNER_S     (OWNER_S),
        .BUSY_S      (BUSY_S)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait (bounded) for slave s to present the address, accept it, then close the response.
    task automatic serve(input int s, input int m);
        int n;
        n = 0;
        while (!AVALID_S[s] && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check($sformatf("serve_avalid_s%0d_m%0d", s, m), 32'(AVALID_S[s]), 32'd1);
        AREADY_S[s] = 1'b1;
        @(negedge ACLK);
        AREADY_S[s]    = 1'b0;
        AVALID_M[m]    = 1'b0;
        RESP_LAST_S[s] = 1'b1;
        @(negedge ACLK);
        RESP_LAST_S[s] = 1'b0;
    endtask

    // Monitor: inputs change only at negedge, so +3 sees the values the next posedge uses.
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            #3;
            if (ARESETn) begin
                for (int s = 0; s <= NS; s++) begin
                    if (AVALID_S[s] && AREADY_S[s]) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL hs_unexpected: slave %0d sel %b, nothing expected",
                                     s, SEL_S[s]);
                        end else begin
                            e = exp_q.pop_front();
                            check("hs_slave", 32'(s), 32'(e.slave));
                            check("hs_sel", 32'(SEL_S[s]), 32'(e.master));
                            check("hs_aready_m", 32'(AREADY_M & e.master), 32'(e.master));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t3_addr [5];
        int          t3_slv  [5];
        t3_addr = '{32'h0000_1FFF, 32'h0000_2000, 32'h1002_0200, 32'h1002_0201, 32'h201F_FFFF};
        t3_slv  = '{0, 6, 3, 6, 5};

        AVALID_M    = '0;
        AADDR_M     = '0;
        AREADY_S    = '0;
        RESP_LAST_S = '0;

        // Reset values
        @(negedge ACLK);
        check("rst_avalid_s", 32'(AVALID_S), 32'd0);
        check("rst_aready_m", 32'(AREADY_M), 32'd0);
        check("rst_sel", 32'(SEL_S), 32'd0);
        check("rst_owner", 32'(OWNER_S), 32'd0);
        check("rst_busy", 32'(BUSY_S), 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);

        // 1: single transaction to DM
        exp_q.push_back('{2, 3'b001});
        AVALID_M[0] = 1'b1;
        AADDR_M[0]  = 32'h0002_0004;
        #1 check("t1_no_early", 32'(AVALID_S), 32'd0);
        @(negedge ACLK);
        check("t1_avalid", 32'(AVALID_S), 32'b0000100);
        check("t1_sel", 32'(SEL_S[2]), 32'b001);
        AREADY_S[2]    = 1'b1;
        RESP_LAST_S[2] = 1'b1;   // ignored outside RESP
        #1 check("t1_aready_m", 32'(AREADY_M), 32'b001);
        @(negedge ACLK);
        AREADY_S[2]    = 1'b0;
        RESP_LAST_S[2] = 1'b0;
        AVALID_M[0]    = 1'b0;
        check("t1_avalid_resp", 32'(AVALID_S), 32'd0);
        check("t1_owner", 32'(OWNER_S[2]), 32'b001);
        @(negedge ACLK);
        check("t1_owner_hold", 32'(OWNER_S[2]), 32'b001);
        check("t1_busy_hold", 32'(BUSY_S), 32'b0000100);
        RESP_LAST_S[2] = 1'b1;
        @(negedge ACLK);
        RESP_LAST_S[2] = 1'b0;
        check("t1_busy_drop", 32'(BUSY_S), 32'd0);
        check("t1_owner_clr", 32'(OWNER_S), 32'd0);

        // 2: round-robin on DRAM; M0 re-requests and must wait for M2
        exp_q.push_back('{5, 3'b001});
        exp_q.push_back('{5, 3'b010});
        exp_q.push_back('{5, 3'b100});
        exp_q.push_back('{5, 3'b001});
        AVALID_M = 3'b111;
        for (int m = 0; m < NM; m++) AADDR_M[m] = 32'h2000_0000;
        serve(5, 0);
        AVALID_M[0] = 1'b1;
        serve(5, 1);
        serve(5, 2);
        serve(5, 0);

        // 3: map boundaries
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{t3_slv[i], 3'b001});
            AVALID_M[0] = 1'b1;
            AADDR_M[0]  = t3_addr[i];
            serve(t3_slv[i], 0);
        end

        // 4: master lock
        exp_q.push_back('{2, 3'b001});
        AVALID_M[0] = 1'b1;
        AADDR_M[0]  = 32'h0002_0000;
        @(negedge ACLK);
        check("t4_dm_addr", 32'(AVALID_S[2]), 32'd1);
        AREADY_S[2] = 1'b1;
        @(negedge ACLK);
        AREADY_S[2] = 1'b0;
        AADDR_M[0]  = 32'h0001_0000;
        exp_q.push_back('{1, 3'b001});
        repeat (2) begin
            @(negedge ACLK);
            check("t4_im_locked", 32'(BUSY_S[1]), 32'd0);
        end
        RESP_LAST_S[2] = 1'b1;
        @(negedge ACLK);
        RESP_LAST_S[2] = 1'b0;
        check("t4_im_wait", 32'(BUSY_S[1]), 32'd0);
        check("t4_dm_free", 32'(BUSY_S[2]), 32'd0);
        @(negedge ACLK);
        check("t4_im_addr", 32'(AVALID_S[1]), 32'd1);
        check("t4_im_sel", 32'(SEL_S[1]), 32'b001);
        serve(1, 0);

        // 5: parallel grants, then back-to-back IM with a forced idle cycle
        exp_q.push_back('{1, 3'b001});
        exp_q.push_back('{2, 3'b010});
        AVALID_M[0] = 1'b1;
        AADDR_M[0]  = 32'h0001_0000;
        AVALID_M[1] = 1'b1;
        AADDR_M[1]  = 32'h0002_0000;
        @(negedge ACLK);
        check("t5_both_addr", 32'(AVALID_S), 32'b0000110);
        AREADY_S[1] = 1'b1;
        #1 check("t5_aready_im", 32'(AREADY_M), 32'b001);
        @(negedge ACLK);
        AREADY_S[1]    = 1'b0;
        AVALID_M[0]    = 1'b0;
        AREADY_S[2]    = 1'b1;
        RESP_LAST_S[1] = 1'b1;
        AVALID_M[2]    = 1'b1;
        AADDR_M[2]     = 32'h0001_0000;
        exp_q.push_back('{1, 3'b100});
        #1 check("t5_aready_dm", 32'(AREADY_M), 32'b010);
        @(negedge ACLK);
        AREADY_S[2]    = 1'b0;
        AVALID_M[1]    = 1'b0;
        RESP_LAST_S[1] = 1'b0;
        RESP_LAST_S[2] = 1'b1;
        check("t5_im_gap", 32'(BUSY_S[1]), 32'd0);
        @(negedge ACLK);
        RESP_LAST_S[2] = 1'b0;
        check("t5_im_m2", 32'(AVALID_S[1]), 32'd1);
        check("t5_im_sel", 32'(SEL_S[1]), 32'b100);
        serve(1, 2);

        // 6: asynchronous reset mid-transaction
        AVALID_M = 3'b111;
        for (int m = 0; m < NM; m++) AADDR_M[m] = 32'h2000_0000;
        @(negedge ACLK);
        check("t6_dram_addr", 32'(AVALID_S[5]), 32'd1);
        AREADY_S[5] = 1'b1;
        #1 check("t6_aready_pre", 32'(AREADY_M), 32'b010);
        #1 ARESETn = 1'b0;
        #1;
        check("t6_avalid_s", 32'(AVALID_S), 32'd0);
        check("t6_aready_m", 32'(AREADY_M), 32'd0);
        check("t6_owner", 32'(OWNER_S), 32'd0);
        check("t6_busy", 32'(BUSY_S), 32'd0);
        @(negedge ACLK);
        AREADY_S[5] = 1'b0;
        ARESETn     = 1'b1;
        exp_q.push_back('{5, 3'b001});
        exp_q.push_back('{5, 3'b010});
        exp_q.push_back('{5, 3'b100});
        serve(5, 0);
        serve(5, 1);
        serve(5, 2);

        repeat (3) @(negedge ACLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_idle", 32'(BUSY_S), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
